rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter for a single shared resource.
- Produces a 2-bit grant code and its one-hot form. The one-hot form comes from an instance of the team's existing 2-to-4 decoder.
- Holds a grant until the owner drops its request or a hold timeout expires, then inserts one dead cycle before the next grant.
- Sits between four bus masters and the shared resource's select logic.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant; legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  arbitration enable; when low, no new grant is issued.
- req  in  4  request lines; req[i] is held high while requester i wants or uses the resource.
- grant_valid  out  1  a grant is active this cycle.
- grant_code  out  2  index of the current owner; holds its last value when grant_valid=0.
- grant  out  4  one-hot grant = decoded grant_code gated by grant_valid; 4'b0000 when no grant.
- preempt  out  1  one-cycle pulse when a grant is ended by timeout.

Behaviour:
- Reset (async assert, sync deassert by the surrounding design):
  - state=IDLE, ptr=0, hold_cnt=0.
  - grant_valid=0, grant_code=2'b00, grant=4'b0000, preempt=0.
- State machine (registered outputs, all transitions on rising clk):
  - IDLE, when en=1 and req!=0:
    - winner = first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1.
    - Next: GRANTED, grant_code=winner, grant_valid=1, hold_cnt=0.
  - IDLE, when en=0 or req=0: stay in IDLE, outputs unchanged.
  - GRANTED, each cycle: hold_cnt increments.
    - Release, when req[grant_code]=0: next RECOVER, grant_valid=0, ptr=grant_code+1 (2-bit wrap, 3 -> 0).
    - Timeout, when req[grant_code]=1 and hold_cnt=MAX_HOLD-1: same transition as release, plus preempt=1 for exactly the next cycle.
    - Release takes precedence over timeout when both occur in the same cycle; preempt stays 0.
    - en going low has no effect on an active grant.
  - RECOVER: unconditional one cycle, then IDLE. Requests are ignored during RECOVER.
- Latency:
  - IDLE with req sampled at edge n -> grant visible after edge n.
  - Owner drops req at edge n -> grant drops after edge n.
  - The earliest next grant appears after edge n+2: one full cycle with grant=0, then one IDLE cycle.
  - Maximum single hold is MAX_HOLD cycles of grant_valid=1.
- Fairness:
  - ptr always points one past the last owner, so a continuously requesting agent waits at most 3 other tenures.
  - A timed-out owner re-competes at lowest priority.
- Simultaneous events:
  - New requests arriving during GRANTED or RECOVER wait.
  - req toggling from non-owners never affects the current grant.
- Reset mid-grant: grant and grant_valid drop immediately (asynchronously); ptr returns to 0.
- Invariant: grant is one-hot or zero; grant_valid=1 iff state=GRANTED.

Decomposition:
- Package rr_arbiter_pkg:
  - state encoding: IDLE=2'd0, GRANTED=2'd1, RECOVER=2'd2.
  - N_REQ=4 and the derived code width 2.
- Sub-module: instantiate the existing decoder_2_4 with code_in=grant_code; its code_out is ANDed with grant_valid to form grant.
- Priority selection is a small combinational function inside rr_arbiter_4; no further sub-modules.

Test Plan:
- Reset/idle: rst=1 with req=4'b1111 -> grant=0000, grant_valid=0. Release rst, en=1 -> next edge grant=0001, grant_code=0.
- Round robin: req=1111 held and each owner drops its req for one cycle after 3 cycles of grant, then re-raises it. Required grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one idle cycle (grant=0000) and one IDLE cycle between tenures.
- Timeout: MAX_HOLD=16, only req[2]=1, held. Required:
  - grant=0100 for exactly 16 cycles;
  - preempt=1 for one cycle with grant=0000;
  - after the IDLE cycle, grant=0100 again (sole requester).
- Release/timeout tie: req[1] drops on the same cycle hold_cnt=15 -> grant ends, preempt stays 0, ptr=2.
- Enable gating: en=0, req=0110 -> no grant for 10 cycles. Raise en -> grant=0010 next edge. Drop en during that grant -> the grant persists until req[1] falls.
- Async reset mid-grant: assert rst between edges while grant=1000 -> grant=0000 immediately without a clock edge. After release -> ptr=0, so req=1001 grants 0001 first.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
// Imported by the arbiter, its bus interface and the bench.
package rr_arbiter_pkg;

    localparam int N_REQ  = 4;
    localparam int CODE_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        RECOVER = 2'd2
    } arb_state_e;

    typedef logic [N_REQ-1:0]  req_vec_t;
    typedef logic [CODE_W-1:0] code_t;

    // Rotate one past the given owner; the 2-bit wrap (3 -> 0) is intentional.
    function automatic code_t next_ptr(input code_t owner);
        return owner + code_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the bus masters and the arbiter.
// master = requesting side, slave = arbiter side.
interface rr_arbiter_4_if;
    import rr_arbiter_pkg::*;

    logic     en;
    req_vec_t req;
    logic     grant_valid;
    code_t    grant_code;
    req_vec_t grant;
    logic     preempt;

    modport master (
        output en, req,
        input  grant_valid, grant_code, grant, preempt
    );

    modport slave (
        input  en, req,
        output grant_valid, grant_code, grant, preempt
    );

endinterface

// File: rtl/decoder_2_4.sv
// Existing 2-to-4 one-hot decoder reused by the arbiter.
module decoder_2_4 (
    input  logic [1:0] code_in,
    output logic [3:0] code_out
);

    assign code_out = 4'b0001 << code_in;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with hold timeout and one dead cycle
// between tenures; grant_code is registered, the one-hot grant is decoded from it.
module rr_arbiter_4
    import rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_4_if.slave  arb
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    code_t            ptr_q, ptr_d;
    code_t            code_q, code_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             pre_q, pre_d;
    req_vec_t         dec_out;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    function automatic code_t pick_winner(input req_vec_t r, input code_t p);
        code_t c;
        code_t w;
        w = p;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            c = p + code_t'(k);
            if (r[c]) w = c;
        end
        return w;
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        code_d  = code_q;
        hold_d  = hold_q;
        pre_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb.en && (|arb.req)) begin
                    state_d = GRANTED;
                    code_d  = pick_winner(arb.req, ptr_q);
                    hold_d  = '0;
                end
            end
            GRANTED: begin
                hold_d = hold_q + 1'b1;
                // Release wins over a coincident timeout, so preempt stays low.
                if (!arb.req[code_q]) begin
                    state_d = RECOVER;
                    ptr_d   = next_ptr(code_q);
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RECOVER;
                    ptr_d   = next_ptr(code_q);
                    pre_d   = 1'b1;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            code_q  <= '0;
            hold_q  <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            code_q  <= code_d;
            hold_q  <= hold_d;
            pre_q   <= pre_d;
        end
    end

    decoder_2_4 u_dec (
        .code_in  (code_q),
        .code_out (dec_out)
    );

    // Decoded from the state register so an async reset clears grant at once.
    assign arb.grant_valid = (state_q == GRANTED);
    assign arb.grant_code  = code_q;
    assign arb.grant       = dec_out & {N_REQ{arb.grant_valid}};
    assign arb.preempt     = pre_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios plus random traffic, each cycle
// compared against a tenure-level reference model.
module tb_rr_arbiter_4;
    import rr_arbiter_pkg::*;

    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    rr_arbiter_4_if bus();

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    always #5 clk = ~clk;

    // Reference model: who owns, how long they have held, whether a dead cycle is pending.
    int m_owner, m_held, m_ptr, m_code;
    bit m_cool, m_pre;

    wire [7:0] obs = {bus.grant_valid, bus.grant_code, bus.grant, bus.preempt};

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_ptr = 0; m_code = 0; m_cool = 0; m_pre = 0;
    endtask

    task automatic model_step(input logic e, input logic [3:0] r);
        m_pre = 0;
        if (m_owner >= 0) begin
            if (!r[m_owner] || m_held == MAX_HOLD) begin
                m_pre   = r[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_held++;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (e && r != 4'b0) begin
            for (int k = 3; k >= 0; k--)
                if (r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            m_code = m_owner;
            m_held = 1;
        end
    endtask

    function automatic logic [7:0] expv();
        logic [3:0] g;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        return {(m_owner >= 0), 2'(m_code), g, m_pre};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(bus.en, bus.req);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.en = 1'b0; bus.req = 4'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.en = 1'b1; bus.req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (obs !== 8'b0) begin
            fails++; $display("FAIL reset_state: got %b want %b", obs, 8'b0);
        end
        rst = 1'b0;
        model_reset();
        tick();
        tests++;
        if (bus.grant !== 4'b0001 || bus.grant_code !== 2'd0) begin
            fails++; $display("FAIL reset_first_grant: got %b/%0d want 0001/0", bus.grant, bus.grant_code);
        end
        tests++;
        if (obs !== expv()) begin
            fails++; $display("FAIL reset_model: got %b want %b", obs, expv());
        end
    endtask

    task automatic test_round_robin();
        int held, gap, cyc;
        logic [3:0] seq[$];
        logic [3:0] exp_seq[5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        held = 0; gap = 0; cyc = 0;
        do_reset();
        bus.en = 1'b1;
        while (seq.size() < 5 && cyc < 80) begin
            bus.req = (held == 3) ? (4'hF & ~bus.grant) : 4'hF;
            tick();
            cyc++;
            tests++;
            if (obs !== expv()) begin
                fails++; $display("FAIL rr_cycle %0d: got %b want %b", cyc, obs, expv());
            end
            if (bus.grant != 4'b0) begin
                if (held == 0) begin
                    if (seq.size() > 0) begin
                        tests++;
                        if (gap != 2) begin
                            fails++; $display("FAIL rr_gap: got %0d idle cycles want 2", gap);
                        end
                    end
                    seq.push_back(bus.grant);
                end
                held++; gap = 0;
            end else begin
                held = 0; gap++;
            end
        end
        tests++;
        if (seq.size() != 5) begin
            fails++; $display("FAIL rr_budget: got %0d tenures want 5", seq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (seq[i] !== exp_seq[i]) begin
                    fails++; $display("FAIL rr_seq[%0d]: got %b want %b", i, seq[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int cnt;
        cnt = 0;
        do_reset();
        bus.en = 1'b1; bus.req = 4'b0100;
        tick();
        while (bus.grant == 4'b0100 && cnt < 40) begin
            tests++;
            if (obs !== expv()) begin
                fails++; $display("FAIL to_cycle: got %b want %b", obs, expv());
            end
            cnt++;
            tick();
        end
        tests++;
        if (cnt != MAX_HOLD) begin
            fails++; $display("FAIL to_len: got %0d cycles want %0d", cnt, MAX_HOLD);
        end
        tests++;
        if (bus.preempt !== 1'b1 || bus.grant !== 4'b0) begin
            fails++; $display("FAIL to_preempt: got pre=%b grant=%b want 1/0000", bus.preempt, bus.grant);
        end
        tick();
        tests++;
        if (bus.preempt !== 1'b0 || bus.grant !== 4'b0) begin
            fails++; $display("FAIL to_idle: got pre=%b grant=%b want 0/0000", bus.preempt, bus.grant);
        end
        tick();
        tests++;
        if (bus.grant !== 4'b0100) begin
            fails++; $display("FAIL to_regrant: got %b want 0100", bus.grant);
        end
    endtask

    task automatic test_tie();
        int held;
        do_reset();
        bus.en = 1'b1; bus.req = 4'b0010;
        tick();
        held = 1;
        while (held < MAX_HOLD) begin
            tick();
            held++;
        end
        tests++;
        if (bus.grant !== 4'b0010) begin
            fails++; $display("FAIL tie_hold: got %b want 0010", bus.grant);
        end
        bus.req = 4'b0000;
        tick();
        tests++;
        if (bus.grant !== 4'b0 || bus.preempt !== 1'b0) begin
            fails++; $display("FAIL tie_release: got grant=%b pre=%b want 0000/0", bus.grant, bus.preempt);
        end
        bus.req = 4'b1011;
        tick();
        tests++;
        if (bus.grant !== 4'b0) begin
            fails++; $display("FAIL tie_idle: got %b want 0000", bus.grant);
        end
        tick();
        tests++;
        if (bus.grant !== 4'b1000) begin
            fails++; $display("FAIL tie_ptr: got %b want 1000", bus.grant);
        end
    endtask

    task automatic test_enable();
        do_reset();
        bus.en = 1'b0; bus.req = 4'b0110;
        repeat (10) begin
            tick();
            tests++;
            if (bus.grant !== 4'b0 || obs !== expv()) begin
                fails++; $display("FAIL en_gate: got %b want %b", obs, expv());
            end
        end
        bus.en = 1'b1;
        tick();
        tests++;
        if (bus.grant !== 4'b0010) begin
            fails++; $display("FAIL en_grant: got %b want 0010", bus.grant);
        end
        bus.en = 1'b0;
        repeat (3) begin
            tick();
            tests++;
            if (bus.grant !== 4'b0010) begin
                fails++; $display("FAIL en_persist: got %b want 0010", bus.grant);
            end
        end
        bus.req = 4'b0100;
        tick();
        tests++;
        if (bus.grant !== 4'b0 || obs !== expv()) begin
            fails++; $display("FAIL en_release: got %b want %b", obs, expv());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.en = 1'b1; bus.req = 4'b1000;
        tick();
        tests++;
        if (bus.grant !== 4'b1000) begin
            fails++; $display("FAIL ar_setup: got %b want 1000", bus.grant);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bus.grant !== 4'b0 || bus.grant_valid !== 1'b0) begin
            fails++; $display("FAIL ar_async: got grant=%b valid=%b want 0000/0", bus.grant, bus.grant_valid);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b1001;
        tick();
        tests++;
        if (bus.grant !== 4'b0001 || obs !== expv()) begin
            fails++; $display("FAIL ar_ptr: got %b want %b", obs, expv());
        end
    endtask

    task automatic test_random();
        do_reset();
        bus.en = 1'b1; bus.req = 4'($urandom_range(0, 15));
        for (int i = 0; i < 500; i++) begin
            bus.en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) bus.req = 4'($urandom_range(0, 15));
            tick();
            tests++;
            if (obs !== expv()) begin
                fails++; $display("FAIL rand_cycle %0d: got %b want %b", i, obs, expv());
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0; bus.req = 4'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_timeout();
        test_tie();
        test_enable();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
